mem_read_responder: RTL and testbench

Pipelined multicycle main-memory responder that answers the cache fill engine's word requests. Accepts one read or write per cycle on a 16-bit byte address, stores 16-bit words, and returns read data exactly `LATENCY` cycles after the request with a one-cycle `memory_data_valid` strobe. It sits between the I- and D-cache fill logic and the backing store, and is the memory side of the fill handshake.

---
 rtl/mem_read_responder_if.sv | 25 ++
 rtl/mem_read_responder.sv | 92 +++++++++
 tb/tb_mem_read_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_read_responder_if.sv
// Request/return bundle between the cache fill engine (master) and the
// pipelined memory responder (slave).
interface mem_read_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              memory_data_valid;
  logic              busy;
  logic [3:0]        outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, memory_data_valid, busy, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, memory_data_valid, busy, outstanding
  );
endinterface

// File: rtl/mem_read_responder.sv
// Main-memory responder for cache fills: single-cycle writes, reads sampled at
// issue and returned through a fixed LATENCY-stage pipeline with a valid strobe.
module mem_read_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_read_responder_if.slave bus
);
  localparam int unsigned WORDS = 2 ** (ADDR_W - 1);

  logic [DATA_W-1:0] mem [WORDS];

  logic [ADDR_W-2:0] word;
  logic              accept_rd;
  logic              accept_wr;
  logic              retire;
  logic              unused_addr_lsb;

  logic [LATENCY-1:0]             stage_valid;
  logic [LATENCY-1:0][DATA_W-1:0] stage_data;
  logic [LATENCY-1:0]             next_valid;
  logic [LATENCY-1:0][DATA_W-1:0] next_data;
  logic [DATA_W-1:0]              sample;
  logic [3:0]                     count;

  always_comb begin
    word            = bus.addr[ADDR_W-1:1];
    unused_addr_lsb = bus.addr[0];
    accept_rd       = bus.enable & ~bus.wr;
    accept_wr       = bus.enable & bus.wr;
    retire          = stage_valid[LATENCY-1];
    sample          = accept_rd ? mem[word] : '0;
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      mem[word] <= bus.data_in;
    end
  end

  // Stage 0 is the newest entry; a single-stage pipeline has nothing to shift.
  if (LATENCY == 1) begin : g_single
    always_comb begin
      next_valid = accept_rd;
      next_data  = sample;
    end
  end else begin : g_multi
    always_comb begin
      next_valid = {stage_valid[LATENCY-2:0], accept_rd};
      next_data  = {stage_data[LATENCY-2:0], sample};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      stage_data  <= '0;
    end else begin
      stage_valid <= next_valid;
      stage_data  <= next_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({accept_rd, retire})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    bus.memory_data_valid = stage_valid[LATENCY-1];
    bus.data_out          = stage_valid[LATENCY-1] ? stage_data[LATENCY-1] : '0;
    bus.outstanding       = count;
    bus.busy              = (count != 4'd0);
  end

  a_count_range : assert property (@(posedge clk) disable iff (rst)
    count <= 4'(LATENCY));

  a_count_matches_stages : assert property (@(posedge clk) disable iff (rst)
    int'(count) == $countones(stage_valid));
endmodule

// File: tb/tb_mem_read_responder.sv
// Scoreboard bench for mem_read_responder: expected returns are queued at
// issue with their due cycle and checked against the DUT every cycle.
module tb_mem_read_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_read_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_read_responder #(
    .ADDR_W (16),
    .DATA_W (16),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model[int];
  int          cyc       = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          peak      = 0;
  bit          mon_on    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit ev;
    if (mon_on && !rst) begin
      while (sb.size() != 0 && sb[0].due < cyc) begin
        check_eq("missed_strobe", 32'(sb[0].due), 32'(cyc));
        void'(sb.pop_front());
      end
      ev = (sb.size() != 0) && (sb[0].due == cyc);
      check_eq("outstanding", 32'(bus.outstanding), 32'(sb.size()));
      check_eq("busy", 32'(bus.busy), 32'(sb.size() != 0));
      if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
      check_eq("valid", 32'(bus.memory_data_valid), 32'(ev));
      if (ev) begin
        check_eq("data", 32'(bus.data_out), 32'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        check_eq("idle_data", 32'(bus.data_out), 32'h0);
      end
    end
  end

  task automatic drive(input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    if (en && w) model[int'(a[15:1])] = d;
    if (en && !w) sb.push_back('{model[int'(a[15:1])], cyc + LAT - 1});
    bus.enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] a;
    rst         = 1'b1;
    bus.enable  = 1'($urandom);
    bus.wr      = 1'($urandom);
    bus.addr    = 16'($urandom);
    bus.data_in = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus.memory_data_valid), 32'h0);
    check_eq("rst_data", 32'(bus.data_out), 32'h0);
    check_eq("rst_outstanding", 32'(bus.outstanding), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    bus.enable = 1'b0;
    rst        = 1'b0;
    mon_on     = 1'b1;
    idle(10);

    // single read
    drive(1'b1, 1'b1, 16'h0024, 16'hBEEF);
    drive(1'b1, 1'b0, 16'h0024, 16'h0);
    idle(6);

    // block fill
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'h1230 + 16'(2 * i), 16'hA000 + 16'(i));
    peak = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0);
    idle(LAT + 2);
    check_eq("peak_outstanding", 32'(peak), 32'(LAT));

    // read-at-issue
    drive(1'b1, 1'b1, 16'h0100, 16'h1111);
    drive(1'b1, 1'b0, 16'h0100, 16'h0);
    drive(1'b1, 1'b1, 16'h0100, 16'h2222);
    drive(1'b1, 1'b0, 16'h0100, 16'h0);
    idle(6);

    // address bit 0 ignored
    drive(1'b1, 1'b1, 16'h0041, 16'h5A5A);
    drive(1'b1, 1'b0, 16'h0040, 16'h0);
    idle(6);

    // fill-engine pattern: hold one address for 4 reads
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h1234, 16'h0);
    idle(6);

    // randomized mix over a small preloaded region
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'h3000 + 16'(2 * i), 16'($urandom));
    for (int i = 0; i < 60; i++) begin
      a = 16'h3000 + 16'(2 * $urandom_range(0, 7)) + 16'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a, 16'($urandom));
    end
    idle(6);

    // reset mid-flight
    drive(1'b1, 1'b1, 16'h0200, 16'h0077);
    drive(1'b1, 1'b0, 16'h0200, 16'h0);
    drive(1'b1, 1'b0, 16'h0024, 16'h0);
    drive(1'b1, 1'b0, 16'h0100, 16'h0);
    idle(2);
    rst = 1'b1;
    sb.delete();
    #1;
    check_eq("midrst_outstanding", 32'(bus.outstanding), 32'h0);
    check_eq("midrst_valid", 32'(bus.memory_data_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    drive(1'b1, 1'b0, 16'h0200, 16'h0);
    drive(1'b1, 1'b0, 16'h0024, 16'h0);
    idle(2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check_eq("drain", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
